dcs_result_packer: RTL and testbench

//  Output stage directly downstream of the DCSformer core. Captures each 8-word x 32-bit

---
 rtl/dcs_result_packer.sv | 212 +++++++++++++++++++++
 tb/tb_dcs_result_packer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcs_result_packer.sv
// DCSformer output stage: saturating requantization of result words into a two-bank
// ping-pong byte buffer drained over valid/ready. Define DCS_PACKER_ARGMAX_EN for an argmax beat.
module dcs_result_packer #(
  parameter int WORDS = 8,
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             ovf,
  output logic             busy
);

  localparam int            CW       = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SEND = 2'd1,
    R_IDX  = 2'd2
  } rstate_t;

  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] q;
    q = d >> SHIFT;
    if (|q[IN_W-1:OUT_W]) return {OUT_W{1'b1}};
    else return q[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] bank_r [2][WORDS];
  logic [1:0]       full_r;
  logic             wr_bank_r;
  logic             rd_bank_r;
  logic [CW-1:0]    wcnt_r;
  logic [CW-1:0]    rcnt_r;
  logic             drop_r;
  rstate_t          state_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic             out_last_r;
  logic             ovf_r;
  logic             busy_r;
`ifdef DCS_PACKER_ARGMAX_EN
  logic [IN_W-1:0]  max_r [2];
  logic [CW-1:0]    idx_r [2];
`endif

  logic             free_s;
  logic             wr_blocked_s;
  logic             start_drop_s;
  logic             accept_s;
  logic             cap_last_s;
  logic             cur_rd_full_s;
  logic             next_rd_full_s;
  logic [1:0]       full_nxt_s;
  logic [CW-1:0]    wcnt_nxt_s;
  logic             drop_nxt_s;

  // Bank release: the accepted final beat of the vector currently draining.
  always_comb begin
`ifdef DCS_PACKER_ARGMAX_EN
    free_s = (state_r == R_IDX) && out_ready;
`else
    free_s = (state_r == R_SEND) && out_ready && (rcnt_r == LAST_IDX);
`endif
  end

  // Capture decisions; a bank freed this cycle may already take word 0 of the next vector.
  always_comb begin
    wr_blocked_s   = full_r[wr_bank_r] && !(free_s && (rd_bank_r == wr_bank_r));
    start_drop_s   = in_valid && !drop_r && (wcnt_r == ZERO_CNT) && wr_blocked_s;
    accept_s       = in_valid && !drop_r && !start_drop_s;
    cap_last_s     = accept_s && (wcnt_r == LAST_IDX);
    cur_rd_full_s  = full_r[rd_bank_r] || (cap_last_s && (wr_bank_r == rd_bank_r));
    next_rd_full_s = full_r[~rd_bank_r] || (cap_last_s && (wr_bank_r != rd_bank_r));
    full_nxt_s[0]  = (full_r[0] && !(free_s && !rd_bank_r)) || (cap_last_s && !wr_bank_r);
    full_nxt_s[1]  = (full_r[1] && !(free_s && rd_bank_r)) || (cap_last_s && wr_bank_r);
    if (in_valid) begin
      wcnt_nxt_s = (wcnt_r == LAST_IDX) ? ZERO_CNT : (wcnt_r + CW'(1));
    end else begin
      wcnt_nxt_s = wcnt_r;
    end
    if (start_drop_s) begin
      drop_nxt_s = 1'b1;
    end else if (in_valid && (wcnt_r == LAST_IDX)) begin
      drop_nxt_s = 1'b0;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // Write side: bank storage, fill flags, word counter and drop tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < WORDS; i++) begin
          bank_r[b][i] <= {OUT_W{1'b0}};
        end
`ifdef DCS_PACKER_ARGMAX_EN
        max_r[b] <= {IN_W{1'b0}};
        idx_r[b] <= ZERO_CNT;
`endif
      end
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      wcnt_r    <= ZERO_CNT;
      drop_r    <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      full_r    <= full_nxt_s;
      wcnt_r    <= wcnt_nxt_s;
      drop_r    <= drop_nxt_s;
      ovf_r     <= ovf_r || start_drop_s;
      busy_r    <= (|full_nxt_s) || (wcnt_nxt_s != ZERO_CNT) || drop_nxt_s;
      if (cap_last_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
      if (accept_s) begin
        bank_r[wr_bank_r][wcnt_r] <= requant(in_data);
      end
`ifdef DCS_PACKER_ARGMAX_EN
      // Strict compare keeps the lowest index on ties.
      if (accept_s && ((wcnt_r == ZERO_CNT) || (in_data > max_r[wr_bank_r]))) begin
        max_r[wr_bank_r] <= in_data;
        idx_r[wr_bank_r] <= wcnt_r;
      end
`endif
    end
  end

  // Read FSM with registered stream outputs; looks ahead at this cycle's capture so
  // out_valid rises right after the final word is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= R_IDLE;
      rd_bank_r   <= 1'b0;
      rcnt_r      <= ZERO_CNT;
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (free_s) begin
      rd_bank_r  <= ~rd_bank_r;
      rcnt_r     <= ZERO_CNT;
      out_last_r <= 1'b0;
      if (next_rd_full_s) begin
        state_r     <= R_SEND;
        out_valid_r <= 1'b1;
        out_data_r  <= bank_r[~rd_bank_r][ZERO_CNT];
      end else begin
        state_r     <= R_IDLE;
        out_valid_r <= 1'b0;
        out_data_r  <= {OUT_W{1'b0}};
      end
    end else begin
      case (state_r)
        R_IDLE: begin
          if (cur_rd_full_s) begin
            state_r     <= R_SEND;
            out_valid_r <= 1'b1;
            out_data_r  <= bank_r[rd_bank_r][ZERO_CNT];
            out_last_r  <= 1'b0;
            rcnt_r      <= ZERO_CNT;
          end
        end
        R_SEND: begin
          if (out_ready && (rcnt_r != LAST_IDX)) begin
            rcnt_r     <= rcnt_r + CW'(1);
            out_data_r <= bank_r[rd_bank_r][rcnt_r + CW'(1)];
`ifdef DCS_PACKER_ARGMAX_EN
            out_last_r <= 1'b0;
`else
            out_last_r <= ((rcnt_r + CW'(1)) == LAST_IDX);
`endif
          end
`ifdef DCS_PACKER_ARGMAX_EN
          else if (out_ready) begin
            state_r    <= R_IDX;
            out_data_r <= {{(OUT_W-CW){1'b0}}, idx_r[rd_bank_r]};
            out_last_r <= 1'b1;
          end
`endif
        end
`ifdef DCS_PACKER_ARGMAX_EN
        R_IDX: begin
          out_valid_r <= 1'b1;
        end
`endif
        default: begin
          state_r     <= R_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dcs_result_packer.sv
// Scoreboard bench for dcs_result_packer: stimulus queues hand-computed beats, a
// negedge monitor pops and compares each transfer and checks stall stability.
module tb_dcs_result_packer;

  typedef logic [31:0] wvec_t [8];
  typedef logic [7:0]  bvec_t [8];
  typedef struct packed { logic [7:0] d; logic l; } beat_t;

`ifdef DCS_PACKER_ARGMAX_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        ovf;
  logic        busy;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  dcs_result_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_vec(input bvec_t b, input int idx);
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      e.d = b[i];
`ifdef DCS_PACKER_ARGMAX_EN
      e.l = 1'b0;
`else
      e.l = (i == 7);
`endif
      exp_q.push_back(e);
    end
`ifdef DCS_PACKER_ARGMAX_EN
    exp_q.push_back({8'(idx), 1'b1});
`else
    if (idx < 0) $display("note: negative argmax index %0d", idx);
`endif
  endtask

  // Word i = (base+i) << 8, which requantizes to byte base+i; the max is the last word.
  task automatic seq_vec(input logic [7:0] base, output wvec_t w, output bvec_t b);
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'(base + i);
      w[i] = {16'h0000, b[i], 8'h00};
    end
  endtask

  task automatic send_vec(input wvec_t w, input int gap, input bit chk_lat);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      if (chk_lat && i == 7) begin
        @(negedge clk);
        chk("latency_before_last_word", out_valid, 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (i == 3 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (chk_lat) chk("latency_valid_after_last_word", out_valid, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 32'd0);
    chk({tag, "_out_data"},  out_data,  32'd0);
    chk({tag, "_out_last"},  out_last,  32'd0);
    chk({tag, "_ovf"},       ovf,       32'd0);
    chk({tag, "_busy"},      busy,      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every transfer against the scoreboard and check stall stability.
  initial begin
    beat_t      e;
    logic       stall;
    logic [7:0] hd;
    logic       hl;
    stall = 1'b0;
    hd    = 8'h00;
    hl    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!out_valid || out_data !== hd || out_last !== hl) begin
            failures++;
            $display("FAIL hold: actual valid=%0b data=%0h last=%0b required valid=1 data=%0h last=%0b",
                     out_valid, out_data, out_last, hd, hl);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: actual data=%0h last=%0b required no beat", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_last !== e.l) begin
              failures++;
              $display("FAIL beat: actual data=%0h last=%0b required data=%0h last=%0b",
                       out_data, out_last, e.d, e.l);
            end
          end
        end
        stall = out_valid && !out_ready;
        hd    = out_data;
        hl    = out_last;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wvec_t w;
    bvec_t b;
    int    seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    apply_reset("por");

    // Basic vector, ready held high, latency checked around the final word.
    out_ready = 1'b1;
    seq_vec(8'h01, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b1);
    wait_drain("t1_drain");
    chk("t1_busy_idle", busy, 32'd0);
    chk("t1_out_valid_idle", out_valid, 32'd0);

    // Saturation boundaries, with an input gap mid-vector.
    w = '{32'h0001_0000, 32'h0000_00FF, 32'h0000_FF00, 32'h0000_FFFF,
          32'hFFFF_FFFF, 32'h0000_0180, 32'h0000_7F00, 32'h0000_80FF};
    b = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h7F, 8'h80};
    push_vec(b, 4);
    send_vec(w, 3, 1'b0);
    wait_drain("t2_drain");

    // Downstream stall of five cycles mid-vector.
    seq_vec(8'h11, w, b);
    w = '{32'h1100, 32'h2200, 32'h3300, 32'h4400, 32'h5500, 32'h6600, 32'h7700, 32'h8800};
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // Argmax: unique max at 5 with an equal pair below it, then a tie for the max.
    w = '{32'h100, 32'h200, 32'h700, 32'h300, 32'h100, 32'h900, 32'h700, 32'h200};
    b = '{8'h01, 8'h02, 8'h07, 8'h03, 8'h01, 8'h09, 8'h07, 8'h02};
    push_vec(b, 5);
    send_vec(w, 0, 1'b0);
    w = '{32'h100, 32'h200, 32'h900, 32'h300, 32'h100, 32'h400, 32'h900, 32'h200};
    b = '{8'h01, 8'h02, 8'h09, 8'h03, 8'h01, 8'h04, 8'h09, 8'h02};
    push_vec(b, 2);
    send_vec(w, 0, 1'b0);
    wait_drain("t6_argmax_drain");

    // Bank free and word 0 of a new vector on the same edge.
    apply_reset("t5_rst");
    seq_vec(8'h10, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    seq_vec(8'h20, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    chk("t5_both_full_busy", busy, 32'd1);
    out_ready = 1'b1;
    repeat (BEATS - 1) @(posedge clk);
    #1;
    seq_vec(8'h30, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    chk("t5_ovf_after_capture", ovf, 32'd0);
    wait_drain("t5_drain");
    chk("t5_ovf_after_drain", ovf, 32'd0);

    // Three vectors with no drain: the third is dropped.
    out_ready = 1'b0;
    seq_vec(8'hA0, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    seq_vec(8'hB0, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    chk("t4_ovf_before_third", ovf, 32'd0);
    seq_vec(8'hC0, w, b);
    send_vec(w, 0, 1'b0);
    chk("t4_ovf_set", ovf, 32'd1);
    chk("t4_busy", busy, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_ovf_sticky", ovf, 32'd1);

    // Reset during a drain discards the rest; nothing emits until a full new vector.
    out_ready = 1'b0;
    seq_vec(8'h40, w, b);
    push_vec(b, 7);
    send_vec(w, 0, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply_reset("mid_rst");
    out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_beats", seen, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_5000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("partial_no_valid", out_valid, 32'd0);
    chk("partial_busy", busy, 32'd1);

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
